// File: rtl/conv_tile_driver_pkg.sv
// Shared constants, derived-width helpers and FSM encoding for the conv tile driver
// and anything else (engine wrappers, benches) that needs the same geometry.
package conv_tile_driver_pkg;

    localparam int DEF_KERNEL_SIZE       = 3;
    localparam int DEF_INPUT_TILE_SIZE   = 4;
    localparam int DEF_INPUT_DATA_WIDTH  = 8;
    localparam int DEF_KERNEL_DATA_WIDTH = 8;
    localparam int DEF_CHANNELS          = 3;

    localparam int TIMEOUT_CYCLES = 4096;
    localparam int WAIT_CNT_W     = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        CONV_RST = 3'd2,
        WAIT     = 3'd3,
        DRAIN    = 3'd4
    } state_t;

    function automatic int output_bit_width(int input_data_width, int kernel_data_width);
        return input_data_width + kernel_data_width + 8;
    endfunction

    function automatic int output_tile_size(int input_tile_size, int kernel_size);
        return input_tile_size - kernel_size + 1;
    endfunction

    function automatic int n_in(int input_tile_size, int channels);
        return input_tile_size * input_tile_size * channels;
    endfunction

    function automatic int n_out(int input_tile_size, int kernel_size);
        int edge_len;
        edge_len = output_tile_size(input_tile_size, kernel_size);
        return edge_len * edge_len;
    endfunction

endpackage

// File: rtl/conv_tile_driver_if.sv
// Pixel-in / result-out stream bundle. The driver sits on the slave side: it
// accepts pixels and offers result words; the feeder/sink uses the master side.
interface conv_tile_driver_if
    import conv_tile_driver_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH = DEF_INPUT_DATA_WIDTH,
    parameter int OUTPUT_BIT_WIDTH = output_bit_width(DEF_INPUT_DATA_WIDTH, DEF_KERNEL_DATA_WIDTH)
);
    logic                               in_valid;
    logic                               in_ready;
    logic signed [INPUT_DATA_WIDTH-1:0] in_data;
    logic                               out_valid;
    logic                               out_ready;
    logic signed [OUTPUT_BIT_WIDTH-1:0] out_data;
    logic                               out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/conv_result_serializer.sv
// Holds the engine's full result tile and streams it out one word per accepted
// out_valid/out_ready transfer, flagging the final word with out_last.
module conv_result_serializer #(
    parameter int N_OUT            = 4,
    parameter int OUTPUT_BIT_WIDTH = 24
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              capture,
    input  logic                              active,
    input  logic [N_OUT*OUTPUT_BIT_WIDTH-1:0] result_in,
    input  logic                              out_ready,
    output logic                              out_valid,
    output logic signed [OUTPUT_BIT_WIDTH-1:0] out_data,
    output logic                              out_last,
    output logic                              done
);
    localparam int J_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic [N_OUT*OUTPUT_BIT_WIDTH-1:0] result;
    logic [J_W-1:0]                    j_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            result <= '0;
            j_cnt  <= '0;
        end else if (capture) begin
            result <= result_in;
            j_cnt  <= '0;
        end else if (active && out_ready) begin
            j_cnt <= out_last ? '0 : j_cnt + 1'b1;
        end
    end

    // Word index only moves on a completed transfer, so data/last hold during a stall.
    assign out_valid = active;
    assign out_last  = active && (j_cnt == J_W'(N_OUT - 1));
    assign out_data  = result[j_cnt*OUTPUT_BIT_WIDTH +: OUTPUT_BIT_WIDTH];
    assign done      = active && out_ready && out_last;

endmodule

// File: rtl/conv_tile_driver.sv
// Gathers a pixel tile and kernel for a convolution engine, pulses the engine
// reset, waits (with timeout) for completion, then streams the result tile out.
module conv_tile_driver
    import conv_tile_driver_pkg::*;
#(
    parameter int KERNEL_SIZE       = DEF_KERNEL_SIZE,
    parameter int INPUT_TILE_SIZE   = DEF_INPUT_TILE_SIZE,
    parameter int INPUT_DATA_WIDTH  = DEF_INPUT_DATA_WIDTH,
    parameter int KERNEL_DATA_WIDTH = DEF_KERNEL_DATA_WIDTH,
    parameter int CHANNELS          = DEF_CHANNELS,
    localparam int OUTPUT_BIT_WIDTH = output_bit_width(INPUT_DATA_WIDTH, KERNEL_DATA_WIDTH),
    localparam int N_IN             = n_in(INPUT_TILE_SIZE, CHANNELS),
    localparam int N_OUT            = n_out(INPUT_TILE_SIZE, KERNEL_SIZE),
    localparam int KW               = KERNEL_SIZE * KERNEL_SIZE * KERNEL_DATA_WIDTH * CHANNELS
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [KW-1:0]                     kernel_in,
    conv_tile_driver_if.slave                 bus,
    output logic                              conv_reset,
    output logic [KW-1:0]                     conv_kernel,
    output logic [N_IN*INPUT_DATA_WIDTH-1:0]  conv_inp_data,
    input  logic [N_OUT*OUTPUT_BIT_WIDTH-1:0] conv_out_data,
    input  logic                              conv_final,
    output logic                              busy,
    output logic                              timeout
);
    localparam int K_W = $clog2(N_IN + 1);

    state_t                state, next_state;
    logic [K_W-1:0]        k_cnt;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  in_ready;
    logic                  load_xfer;
    logic                  last_load;
    logic                  wait_expired;
    logic                  capture;
    logic                  drain_active;
    logic                  drain_done;

    assign load_xfer    = (state == LOAD) && bus.in_valid;
    assign last_load    = (k_cnt == K_W'(N_IN - 1));
    assign wait_expired = (wait_cnt == WAIT_CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus.in_ready = in_ready;

    // NOTE: every clocked process uses non-blocking <= so all flops update from
    // the same pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: each output of this block gets a default before the case so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        next_state   = state;
        in_ready     = 1'b0;
        capture      = 1'b0;
        drain_active = 1'b0;
        busy         = (state != IDLE);
        unique case (state)
            IDLE: if (start) next_state = LOAD;
            LOAD: begin
                in_ready = 1'b1;
                if (load_xfer && last_load) next_state = CONV_RST;
            end
            CONV_RST: next_state = WAIT;
            WAIT: begin
                if (conv_final) begin
                    capture    = 1'b1;
                    next_state = DRAIN;
                end else if (wait_expired) begin
                    next_state = IDLE;
                end
            end
            DRAIN: begin
                drain_active = 1'b1;
                if (drain_done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Engine reset is held while the driver itself is in reset.
    assign conv_reset = (state == CONV_RST) || !reset;

    // NOTE: the tile register is reset like the rest of the state because an
    // aborted job must not leave stale pixels in front of the engine.
    always_ff @(posedge clk) begin
        if (!reset) begin
            k_cnt         <= '0;
            wait_cnt      <= '0;
            conv_inp_data <= '0;
            conv_kernel   <= '0;
            timeout       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    conv_kernel <= kernel_in;
                    k_cnt       <= '0;
                    timeout     <= 1'b0;
                end
                LOAD: if (load_xfer) begin
                    conv_inp_data[k_cnt*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH] <= bus.in_data;
                    k_cnt <= k_cnt + 1'b1;
                end
                CONV_RST: wait_cnt <= '0;
                WAIT: if (!conv_final) begin
                    if (wait_expired) timeout  <= 1'b1;
                    else              wait_cnt <= wait_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    conv_result_serializer #(
        .N_OUT            (N_OUT),
        .OUTPUT_BIT_WIDTH (OUTPUT_BIT_WIDTH)
    ) u_serializer (
        .clk       (clk),
        .reset     (reset),
        .capture   (capture),
        .active    (drain_active),
        .result_in (conv_out_data),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .out_last  (bus.out_last),
        .done      (drain_done)
    );

endmodule

// File: tb/tb_conv_tile_driver.sv
// Directed bench for conv_tile_driver with a stub engine that raises conv_final
// a fixed number of cycles after the conv_reset pulse.
module tb_conv_tile_driver;
    localparam int IDW   = 8;
    localparam int OBW   = 24;
    localparam int N_IN  = 48;
    localparam int N_OUT = 4;
    localparam int KW    = 216;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   start = 1'b0;
    logic [KW-1:0]          kernel_in = '0;
    logic                   conv_reset;
    logic [KW-1:0]          conv_kernel;
    logic [N_IN*IDW-1:0]    conv_inp_data;
    logic [N_OUT*OBW-1:0]   conv_out_data;
    logic                   conv_final;
    logic                   busy;
    logic                   timeout;

    conv_tile_driver_if #(.INPUT_DATA_WIDTH(IDW), .OUTPUT_BIT_WIDTH(OBW)) bus();

    conv_tile_driver dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .kernel_in     (kernel_in),
        .bus           (bus),
        .conv_reset    (conv_reset),
        .conv_kernel   (conv_kernel),
        .conv_inp_data (conv_inp_data),
        .conv_out_data (conv_out_data),
        .conv_final    (conv_final),
        .busy          (busy),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub engine: conv_final is high in the 5th cycle after the conv_reset cycle.
    logic signed [OBW-1:0] eng_words [N_OUT];
    bit engine_en = 1'b1;
    int eng_cnt = 0;
    always @(negedge clk) begin
        if (conv_reset && busy)                eng_cnt <= 1;
        else if (eng_cnt != 0 && eng_cnt < 20) eng_cnt <= eng_cnt + 1;
        else                                   eng_cnt <= 0;
    end
    assign conv_final = engine_en && (eng_cnt == 6);
    always_comb begin
        conv_out_data = '0;
        for (int i = 0; i < N_OUT; i++) conv_out_data[i*OBW +: OBW] = eng_words[i];
    end

    int total = 0;
    int bad = 0;
    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [KW-1:0]       k1, k2, kx;
    logic [IDW-1:0]      pix [N_IN];
    logic [N_IN*IDW-1:0] exp_tile;
    int s_cyc;

    task automatic build_tile();
        for (int i = 0; i < N_IN; i++) exp_tile[i*IDW +: IDW] = pix[i];
    endtask

    task automatic do_start(input logic [KW-1:0] k);
        kernel_in = k;
        start     = 1'b1;
        s_cyc     = cyc;
        tick();
        start     = 1'b0;
        kernel_in = kx;
    endtask

    task automatic load_pixels(input int n, input bit gapped, input int start_at);
        for (int i = 0; i < n; i++) begin
            bit acc = 1'b0;
            if (gapped && (i % 3 == 1)) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'hEE;
                tick();
            end
            bus.in_valid = 1'b1;
            bus.in_data  = pix[i];
            for (int b = 0; b < 20 && !acc; b++) begin
                if (i == start_at && b == 0) begin
                    start     = 1'b1;
                    kernel_in = kx;
                end
                acc = bus.in_ready;
                tick();
                start = 1'b0;
            end
            if (!acc) begin
                check("load_ready_wait", 0, 1);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic after_load(input bit check_idx);
        check("conv_reset_pulse", conv_reset, 1);
        if (check_idx) check("conv_reset_cycle", cyc - s_cyc + 1, N_IN + 2);
        check("tile_data", conv_inp_data, exp_tile);
        tick();
        check("conv_reset_width", conv_reset, 0);
    endtask

    task automatic drain(input bit toggle, input bit start_pulse, input int exp_lat);
        int w = 0;
        int j = 0;
        int c = 0;
        while (!bus.out_valid && w < 200) begin
            tick();
            w++;
        end
        if (!bus.out_valid) begin
            check("drain_wait", 0, 1);
            return;
        end
        if (exp_lat >= 0) check("latency", cyc - s_cyc + 1, exp_lat);
        while (j < N_OUT && c < 100) begin
            bus.out_ready = toggle ? (c % 2 == 1) : 1'b1;
            if (start_pulse && c == 0) begin
                start     = 1'b1;
                kernel_in = kx;
            end
            check("out_valid", bus.out_valid, 1);
            check($sformatf("out_data[%0d]", j), bus.out_data, eng_words[j]);
            check($sformatf("out_last[%0d]", j), bus.out_last, (j == N_OUT - 1));
            if (bus.out_ready) j++;
            tick();
            start = 1'b0;
            c++;
        end
        bus.out_ready = 1'b0;
        check("drain_count", j, N_OUT);
        check("busy_after_drain", busy, 0);
        check("valid_after_drain", bus.out_valid, 0);
    endtask

    initial begin
        bit seen_valid;
        int w;
        for (int i = 0; i < KW / 8; i++) begin
            k1[i*8 +: 8] = 8'(i + 1);
            k2[i*8 +: 8] = 8'(8'hA0 ^ i);
        end
        kx = '1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        check("rst_conv_reset", conv_reset, 1);
        check("rst_conv_kernel", conv_kernel, 0);
        check("rst_tile", conv_inp_data, 0);
        reset = 1'b1;
        tick();

        // Job 1: pixels k, in_valid constant, engine words 1..4, no backpressure
        for (int i = 0; i < N_IN; i++) pix[i] = 8'(i);
        build_tile();
        eng_words[0] = 24'sd1; eng_words[1] = 24'sd2; eng_words[2] = 24'sd3; eng_words[3] = 24'sd4;
        do_start(k1);
        check("kernel_captured", conv_kernel, k1);
        check("busy_load", busy, 1);
        load_pixels(N_IN, 1'b0, -1);
        after_load(1'b1);
        drain(1'b0, 1'b0, N_IN + 2 + 5 + 1);

        // Job 2: gapped pixels, toggling out_ready, start during LOAD and DRAIN
        for (int i = 0; i < N_IN; i++) pix[i] = 8'(i * 37 + 5);
        build_tile();
        eng_words[0] = -24'sd5; eng_words[1] = 24'sh7FFFFF; eng_words[2] = 24'sd0; eng_words[3] = 24'sd12345;
        do_start(k2);
        load_pixels(N_IN, 1'b1, 10);
        check("kernel_hold_load", conv_kernel, k2);
        after_load(1'b0);
        drain(1'b1, 1'b1, -1);
        check("kernel_hold_drain", conv_kernel, k2);
        check("tile_hold_drain", conv_inp_data, exp_tile);

        // Reset at pixel 20, then a fresh job
        for (int i = 0; i < N_IN; i++) pix[i] = 8'(200 - 3 * i);
        do_start(k1);
        load_pixels(20, 1'b0, -1);
        reset = 1'b0;
        tick();
        check("abort_in_ready", bus.in_ready, 0);
        check("abort_busy", busy, 0);
        check("abort_tile", conv_inp_data, 0);
        check("abort_kernel", conv_kernel, 0);
        check("abort_conv_reset", conv_reset, 1);
        reset = 1'b1;
        seen_valid = 1'b0;
        repeat (10) begin
            tick();
            if (bus.out_valid) seen_valid = 1'b1;
        end
        check("abort_no_output", seen_valid, 0);
        check("abort_idle", busy, 0);
        build_tile();
        eng_words[0] = 24'sd10; eng_words[1] = -24'sd20; eng_words[2] = 24'sd30; eng_words[3] = -24'sd40;
        do_start(k2);
        check("fresh_kernel", conv_kernel, k2);
        load_pixels(N_IN, 1'b0, -1);
        after_load(1'b1);
        drain(1'b0, 1'b0, N_IN + 2 + 5 + 1);

        // Timeout: engine never completes
        engine_en = 1'b0;
        for (int i = 0; i < N_IN; i++) pix[i] = 8'(i ^ 8'h5A);
        build_tile();
        do_start(k1);
        load_pixels(N_IN, 1'b0, -1);
        after_load(1'b1);
        seen_valid = 1'b0;
        w = 0;
        while (!timeout && w < 5000) begin
            if (bus.out_valid) seen_valid = 1'b1;
            tick();
            w++;
        end
        check("timeout_set", timeout, 1);
        check("timeout_cycle", cyc - s_cyc + 1, N_IN + 3 + 4096);
        check("timeout_idle", busy, 0);
        check("timeout_no_output", seen_valid, 0);
        check("timeout_in_ready", bus.in_ready, 0);
        tick();
        check("timeout_sticky", timeout, 1);
        engine_en = 1'b1;
        do_start(k2);
        check("timeout_cleared", timeout, 0);
        check("restart_busy", busy, 1);
        check("restart_kernel", conv_kernel, k2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("final_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
